// File: rtl/alu.sv
// Multi-cycle signed ALU for use as a small arithmetic co-processor.
// Operations: add, subtract, shift-add multiply (8 cycles) and restoring
// divide (16 cycles). Start/done handshake; the result is held until the
// next operation is started.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request, sampled when not busy
//   op_select  00 add, 01 sub, 10 mul, 11 div
//   op1        signed 16-bit operand A
//   op2        signed 8-bit operand B
//   res        signed result; for div {quotient[7:0], remainder[7:0]}
//   done       high while res holds a valid result
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_select,
    input  logic [15:0] op1,
    input  logic [7:0]  op2,
    output logic [15:0] res,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    // Magnitudes are unsigned, so |-32768| and |-128| fit without overflow.
    logic [15:0] mag_a_q, mag_a_d;
    logic [7:0]  mag_b_q, mag_b_d;
    logic [23:0] acc_q, acc_d;
    logic [8:0]  rem_q, rem_d;
    // Dividend shifts out at the top while quotient bits shift in at the bottom.
    logic [15:0] dvd_q, dvd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        done_q, done_d;

    logic [23:0] mul_term;
    logic [23:0] prod_s;
    logic [8:0]  rem_sh;
    logic [8:0]  rem_new;
    logic        qbit;
    logic [15:0] q_s;
    logic [7:0]  r_s;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        done_d   = done_q;
        mul_term = '0;
        prod_s   = '0;
        rem_sh   = '0;
        rem_new  = '0;
        qbit     = 1'b0;
        q_s      = '0;
        r_s      = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d    = op_select;
                    a_d     = op1;
                    b_d     = op2;
                    mag_a_d = op1[15] ? (~op1 + 16'd1) : op1;
                    mag_b_d = op2[7] ? (~op2 + 8'd1) : op2;
                    acc_d   = '0;
                    rem_d   = '0;
                    dvd_d   = op1[15] ? (~op1 + 16'd1) : op1;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 4'd1;
                case (op_q)
                    OpAdd: begin
                        res_d   = a_q + {{8{b_q[7]}}, b_q};
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                    OpSub: begin
                        res_d   = a_q - {{8{b_q[7]}}, b_q};
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                    OpMul: begin
                        mul_term = mag_b_q[cnt_q[2:0]] ? ({8'd0, mag_a_q} << cnt_q) : 24'd0;
                        acc_d    = acc_q + mul_term;
                        if (cnt_q == 4'd7) begin
                            prod_s  = (a_q[15] ^ b_q[7]) ? (~acc_d + 24'd1) : acc_d;
                            res_d   = prod_s[15:0];
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end
                    OpDiv: begin
                        rem_sh = {rem_q[7:0], dvd_q[15]};
                        if (rem_sh >= {1'b0, mag_b_q}) begin
                            rem_new = rem_sh - {1'b0, mag_b_q};
                            qbit    = 1'b1;
                        end else begin
                            rem_new = rem_sh;
                        end
                        rem_d = rem_new;
                        dvd_d = {dvd_q[14:0], qbit};
                        if (cnt_q == 4'd15) begin
                            q_s = (a_q[15] ^ b_q[7]) ? (~dvd_d + 16'd1) : dvd_d;
                            // Remainder magnitude is below 128, so its 8-bit negation fits.
                            r_s = a_q[15] ? (~rem_new[7:0] + 8'd1) : rem_new[7:0];
                            if (b_q == 8'd0) begin
                                res_d = {8'hFF, a_q[7:0]};
                            end else begin
                                res_d = {q_s[7:0], r_s};
                            end
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign res  = res_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed operations with a result scoreboard,
// latency checks, busy-start rejection, result hold and asynchronous reset.
module tb_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_select;
    logic [15:0] op1;
    logic [7:0]  op2;
    logic [15:0] res;
    logic        done;

    int passed = 0;
    int total  = 0;
    logic [15:0] last_exp;

    typedef struct {
        logic [15:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t scb[$];

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_select (op_select),
        .op1       (op1),
        .op2       (op2),
        .res       (res),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a,
                                          input logic [7:0] b);
        int sa;
        int sbv;
        int p;
        int q;
        int r;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            2'b00: return 16'(sa + sbv);
            2'b01: return 16'(sa - sbv);
            2'b10: begin
                p = sa * sbv;
                return p[15:0];
            end
            default: begin
                if (sbv == 0) return {8'hFF, a[7:0]};
                q = sa / sbv;
                r = sa % sbv;
                return {q[7:0], r[7:0]};
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b10:   return 8;
            2'b11:   return 16;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Starts one operation, scrambles the inputs after the latching edge, optionally
    // pulses start mid-operation, then checks latency and result from the scoreboard.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                          input string tag, input bit pulse_busy);
        exp_t e;
        int   n;
        @(negedge clk);
        op_select = op;
        op1       = a;
        op2       = b;
        start     = 1'b1;
        e.res = model(op, a, b);
        e.lat = lat_of(op);
        e.tag = tag;
        scb.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        op1       = ~a;
        op2       = ~b;
        op_select = ~op;
        check({tag, "/done_clr"}, {31'd0, done}, 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            start = pulse_busy && (n == 2);
            @(posedge clk);
            #1;
            n = n + 1;
        end
        start = 1'b0;
        e = scb.pop_front();
        check({e.tag, "/latency"}, n, e.lat);
        check({e.tag, "/res"}, {16'd0, res}, {16'd0, e.res});
        last_exp = e.res;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        op_select = 2'b00;
        op1       = 16'h0000;
        op2       = 8'h00;
        #2;
        check("reset/res", {16'd0, res}, 32'd0);
        check("reset/done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(2'b00, 16'd10, 8'd5, "add_10_5", 1'b0);
        run_op(2'b00, -16'sd8, 8'd3, "add_m8_3", 1'b0);
        run_op(2'b01, 16'd20, 8'd4, "sub_20_4", 1'b0);
        run_op(2'b01, 16'd7, -8'sd2, "sub_7_m2", 1'b0);
        run_op(2'b01, 16'h8000, 8'd1, "sub_wrap", 1'b0);

        run_op(2'b10, 16'd6, 8'd3, "mul_6_3_busy", 1'b1);
        run_op(2'b10, -16'sd4, 8'd5, "mul_m4_5", 1'b0);
        run_op(2'b10, 16'd10, -8'sd3, "mul_10_m3", 1'b0);
        run_op(2'b10, -16'sd7, -8'sd2, "mul_m7_m2", 1'b0);
        run_op(2'b10, 16'h8000, 8'h80, "mul_min_min", 1'b0);
        run_op(2'b10, 16'd300, 8'd127, "mul_wrap", 1'b0);

        run_op(2'b11, 16'd1234, 8'd33, "div_1234_33", 1'b0);
        run_op(2'b11, 16'd4112, 8'd40, "div_4112_40", 1'b0);
        run_op(2'b11, -16'sd23, 8'd5, "div_m23_5_busy", 1'b1);
        run_op(2'b11, 16'd7, 8'd0, "div_by_zero", 1'b0);
        run_op(2'b11, 16'h8000, 8'h80, "div_min_min", 1'b0);
        run_op(2'b11, 16'd127, -8'sd1, "div_127_m1", 1'b0);

        // Result and done hold in DONE across idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("hold/done", {31'd0, done}, 32'd1);
        check("hold/res", {16'd0, res}, {16'd0, last_exp});

        // Asynchronous reset in the middle of a multiply.
        run_op(2'b10, 16'd100, 8'd50, "mul_pre_reset", 1'b0);
        @(negedge clk);
        op_select = 2'b10;
        op1       = 16'd123;
        op2       = 8'd45;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst/res", {16'd0, res}, 32'd0);
        check("async_rst/done", {31'd0, done}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rst_held/done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b10, -16'sd9, 8'd11, "mul_after_reset", 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom_range(3, 0)), 16'($urandom), 8'($urandom), "random", 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
